// File: rtl/qed_dup_queue.sv
// QED duplication stage: forwards original instructions to the core and queues their
// EDDI-V duplicates (x1-x15 remapped to x17-x31) for replay as a contiguous burst.
module qed_dup_queue #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         qed_enable,
    input  logic                         qed_switch,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instruction,
    input  logic                         in_is_lw,
    input  logic                         in_is_sw,
    input  logic                         in_is_aluimm,
    input  logic                         in_is_alureg,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instruction,
    output logic                         out_is_dup,
    output logic                         dup_active,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [0:0] ORIG = 1'b0;
    localparam logic [0:0] DUP  = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [PW-1:0] wptr_reg, rptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   fifo_mem [DEPTH];
    logic [31:0]   dup_word;
    logic          full, enq, deq, any_class;

    function automatic logic [4:0] remap(input logic [4:0] r);
        return (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
    endfunction

    // Only register specifier fields change; immediates and function codes are copied.
    always_comb begin
        dup_word = in_instruction;
        if (in_is_alureg) begin
            dup_word[11:7]  = remap(in_instruction[11:7]);
            dup_word[19:15] = remap(in_instruction[19:15]);
            dup_word[24:20] = remap(in_instruction[24:20]);
        end else if (in_is_aluimm || in_is_lw) begin
            dup_word[11:7]  = remap(in_instruction[11:7]);
            dup_word[19:15] = remap(in_instruction[19:15]);
        end else if (in_is_sw) begin
            dup_word[19:15] = remap(in_instruction[19:15]);
            dup_word[24:20] = remap(in_instruction[24:20]);
        end
    end

    assign any_class = in_is_lw | in_is_sw | in_is_aluimm | in_is_alureg;
    assign full      = (count_reg == CW'(DEPTH));

    always_comb begin
        if (state_reg == ORIG) begin
            out_valid       = in_valid & ~full;
            in_ready        = out_ready & ~full;
            out_instruction = in_instruction;
            out_is_dup      = 1'b0;
        end else begin
            out_valid       = (count_reg != '0);
            in_ready        = 1'b0;
            out_instruction = fifo_mem[rptr_reg];
            out_is_dup      = 1'b1;
        end
    end

    assign enq = (state_reg == ORIG) & in_valid & in_ready & qed_enable & any_class;
    assign deq = (state_reg == DUP) & out_valid & out_ready;

    always_comb begin
        count_next = count_reg;
        if (enq && !deq)
            count_next = count_reg + 1'b1;
        else if (deq && !enq)
            count_next = count_reg - 1'b1;
    end

    // Same-cycle enqueue counts toward both the full trigger and the switch trigger.
    always_comb begin
        state_next = state_reg;
        if (state_reg == ORIG) begin
            if ((count_next == CW'(DEPTH)) || (qed_switch && (count_next != '0)))
                state_next = DUP;
        end else if (count_next == '0) begin
            state_next = ORIG;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg <= ORIG;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (enq)
                wptr_reg <= wptr_reg + 1'b1;
            if (deq)
                rptr_reg <= rptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            fifo_mem[wptr_reg] <= dup_word;
    end

    assign dup_active  = (state_reg == DUP);
    assign queue_count = count_reg;

endmodule

// File: tb/tb_qed_dup_queue.sv
// Bench for qed_dup_queue: queue-based reference model checked every cycle plus
// directed literal expectations for the documented instruction examples.
module tb_qed_dup_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        qed_enable = 1'b0;
    logic        qed_switch = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instruction = 32'h0;
    logic        in_is_lw = 1'b0, in_is_sw = 1'b0, in_is_aluimm = 1'b0, in_is_alureg = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic        out_is_dup;
    logic        dup_active;
    logic [$clog2(DEPTH+1)-1:0] queue_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mq[$];
    bit          m_dup = 1'b0;

    qed_dup_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l), .qed_enable(qed_enable), .qed_switch(qed_switch),
        .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
        .in_is_lw(in_is_lw), .in_is_sw(in_is_sw), .in_is_aluimm(in_is_aluimm),
        .in_is_alureg(in_is_alureg), .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_is_dup(out_is_dup),
        .dup_active(dup_active), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register numbers below 16 map to the upper bank by adding 16; x0 stays x0.
    function automatic logic [4:0] map_reg(input logic [4:0] r);
        return (r == 5'd0) ? 5'd0 : 5'(r + 5'd16);
    endfunction

    function automatic logic [31:0] model_dup(input logic [31:0] w, input logic lw,
                                              input logic sw, input logic ai, input logic ar);
        logic [31:0] d;
        d = w;
        if (ar || ai || lw) d[11:7] = map_reg(w[11:7]);
        if (ar || ai || lw || sw) d[19:15] = map_reg(w[19:15]);
        if ((ar || sw) && !(ai || lw) || ar) d[24:20] = map_reg(w[24:20]);
        return d;
    endfunction

    function automatic logic [31:0] mk_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin : compare
        bit m_full;
        bit any;
        m_full = (mq.size() == DEPTH);
        any    = in_is_lw | in_is_sw | in_is_aluimm | in_is_alureg;
        if (!rst_l) begin
            mq.delete();
            m_dup = 1'b0;
            chk("rst_dup_active", 32'(dup_active), 32'd0);
            chk("rst_queue_count", 32'(queue_count), 32'd0);
            chk("rst_out_is_dup", 32'(out_is_dup), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'(in_valid));
            chk("rst_in_ready", 32'(in_ready), 32'(out_ready));
        end else begin
            chk("m_dup_active", 32'(dup_active), 32'(m_dup));
            chk("m_queue_count", 32'(queue_count), 32'(mq.size()));
            chk("m_out_is_dup", 32'(out_is_dup), 32'(m_dup));
            if (!m_dup) begin
                chk("m_out_valid", 32'(out_valid), 32'(in_valid && !m_full));
                chk("m_in_ready", 32'(in_ready), 32'(out_ready && !m_full));
                chk("m_out_instr", out_instruction, in_instruction);
                if (out_valid && out_ready)
                    $display("issue orig %h", out_instruction);
                if (in_valid && out_ready && !m_full && qed_enable && any)
                    mq.push_back(model_dup(in_instruction, in_is_lw, in_is_sw,
                                           in_is_aluimm, in_is_alureg));
                if (mq.size() == DEPTH || (qed_switch && mq.size() != 0))
                    m_dup = 1'b1;
            end else begin
                chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
                chk("m_in_ready", 32'(in_ready), 32'd0);
                if (mq.size() != 0) begin
                    chk("m_out_dup_instr", out_instruction, mq[0]);
                    if (out_ready) begin
                        $display("issue dup  %h", out_instruction);
                        void'(mq.pop_front());
                    end
                end
                if (mq.size() == 0)
                    m_dup = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cls = {alureg, aluimm, lw, sw}
    task automatic set_in(input logic v, input logic [31:0] w, input logic [3:0] cls);
        in_valid       = v;
        in_instruction = w;
        in_is_alureg   = cls[3];
        in_is_aluimm   = cls[2];
        in_is_lw       = cls[1];
        in_is_sw       = cls[0];
    endtask

    initial begin
        out_ready  = 1'b1;
        qed_enable = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_l = 1'b1;

        // ADDI x1,x2,5 then switch
        set_in(1'b1, 32'h00510093, 4'b0100);
        @(negedge clk);
        chk("t1_orig_instr", out_instruction, 32'h00510093);
        chk("t1_orig_isdup", 32'(out_is_dup), 32'd0);
        step();
        set_in(1'b0, 32'h0, 4'b0000);
        qed_switch = 1'b1;
        step();
        qed_switch = 1'b0;
        @(negedge clk);
        chk("t1_dup_active", 32'(dup_active), 32'd1);
        chk("t1_dup_instr", out_instruction, 32'h00590893);
        step();
        @(negedge clk);
        chk("t1_back_orig", 32'(dup_active), 32'd0);
        chk("t1_count0", 32'(queue_count), 32'd0);

        // ADD then SW with simultaneous switch
        step();
        set_in(1'b1, 32'h002081B3, 4'b1000);
        step();
        set_in(1'b1, 32'h0020A423, 4'b0001);
        qed_switch = 1'b1;
        step();
        set_in(1'b0, 32'h0, 4'b0000);
        qed_switch = 1'b0;
        @(negedge clk);
        chk("t2_burst0", out_instruction, 32'h012889B3);
        step();
        @(negedge clk);
        chk("t2_burst1", out_instruction, 32'h0128A423);
        step();
        @(negedge clk);
        chk("t2_back_orig", 32'(dup_active), 32'd0);

        // Fill the FIFO: automatic DUP entry, 9th instruction waits for the drain
        step();
        for (int k = 1; k <= DEPTH; k++) begin
            set_in(1'b1, mk_addi(k, k + 1, k), 4'b0100);
            step();
        end
        set_in(1'b1, 32'h000012B7, 4'b0000);
        @(negedge clk);
        chk("t3_full_in_ready", 32'(in_ready), 32'd0);
        chk("t3_full_dup", 32'(dup_active), 32'd1);
        chk("t3_full_count", 32'(queue_count), 32'd8);
        chk("t3_first_dup", out_instruction, 32'h00190893);
        step();
        repeat (DEPTH - 1) step();
        @(negedge clk);
        chk("t3_drained", 32'(dup_active), 32'd0);
        chk("t3_ninth_ready", 32'(in_ready), 32'd1);
        chk("t3_ninth_instr", out_instruction, 32'h000012B7);
        step();
        set_in(1'b0, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t3_count0", 32'(queue_count), 32'd0);

        // Stall in DUP with switch pulses and pending input
        step();
        set_in(1'b1, mk_addi(5, 6, 7), 4'b0100);
        step();
        set_in(1'b1, mk_addi(9, 10, 11), 4'b0100);
        qed_switch = 1'b1;
        step();
        set_in(1'b1, mk_addi(2, 3, 4), 4'b0100);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            qed_switch = i[0];
            @(negedge clk);
            chk("t4_stall_instr", out_instruction, 32'h007B0A93);
            chk("t4_stall_count", 32'(queue_count), 32'd2);
            chk("t4_stall_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready  = 1'b1;
        qed_switch = 1'b0;
        set_in(1'b0, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t4_first", out_instruction, 32'h007B0A93);
        step();
        @(negedge clk);
        chk("t4_second", out_instruction, 32'h00BD0C93);
        step();
        @(negedge clk);
        chk("t4_back_orig", 32'(dup_active), 32'd0);

        // qed_enable=0 pass-through, then switch with an empty queue
        step();
        qed_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, mk_addi(i + 1, i + 2, i), 4'b0100);
            @(negedge clk);
            chk("t5_pass_instr", out_instruction, mk_addi(i + 1, i + 2, i));
            chk("t5_pass_count", 32'(queue_count), 32'd0);
            step();
        end
        set_in(1'b0, 32'h0, 4'b0000);
        qed_switch = 1'b1;
        step();
        qed_switch = 1'b0;
        @(negedge clk);
        chk("t5_empty_switch", 32'(dup_active), 32'd0);

        // Reset mid-burst with three entries queued
        step();
        qed_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, mk_addi(i + 3, i + 4, i + 1), 4'b0100);
            qed_switch = (i == 2);
            step();
        end
        set_in(1'b0, 32'h0, 4'b0000);
        qed_switch = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        chk("t6_burst_active", 32'(dup_active), 32'd1);
        chk("t6_burst_count", 32'(queue_count), 32'd3);
        step();
        #2 rst_l = 1'b0;
        #1;
        chk("t6_rst_dup_active", 32'(dup_active), 32'd0);
        chk("t6_rst_count", 32'(queue_count), 32'd0);
        chk("t6_rst_isdup", 32'(out_is_dup), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_l = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'h00510093, 4'b0100);
        @(negedge clk);
        chk("t6_post_instr", out_instruction, 32'h00510093);
        chk("t6_post_isdup", 32'(out_is_dup), 32'd0);
        step();
        set_in(1'b0, 32'h0, 4'b0000);
        qed_switch = 1'b1;
        @(negedge clk);
        chk("t6_post_count", 32'(queue_count), 32'd1);
        step();
        qed_switch = 1'b0;
        @(negedge clk);
        chk("t6_post_dup", out_instruction, 32'h00590893);
        step();
        @(negedge clk);
        chk("t6_post_orig", 32'(dup_active), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
